reset_seq: RTL
==============

RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 3, giving the number of staged reset outputs (legal 1..8).
REQ-002 The block SHALL have parameter MIN_ASSERT, default 31, giving the minimum cycles all outputs are held asserted (legal >=1).
REQ-003 The block SHALL have parameter STAGE_LEN, default 16, giving the cycles between successive stage releases (legal >=1).
REQ-004 The block SHALL have parameter DEBOUNCE_LEN, default 255, giving the cycles of stable button level needed to accept a change (legal >=1).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port btn_n, input, 1 bit: external reset button, active low, asynchronous to clk.
REQ-008 The block SHALL have port sw_req, input, 1 bit: one-cycle software reset request pulse.
REQ-009 The block SHALL have port rst_n_out, output, NUM_STAGES bits: staged active-low resets; bit 0 releases first.
REQ-010 The block SHALL have port busy, output, 1 bit: high while any rst_n_out bit is low.
REQ-011 The block SHALL have port cause, output, 2 bits: last reset cause; 0 = reset port, 1 = button, 2 = software, 3 = unused.

Function
REQ-012 The block SHALL pass btn_n through a 2-flop synchronizer before any other use.
REQ-013 The debounced button state SHALL change only after the synchronized level has differed from it for DEBOUNCE_LEN consecutive cycles; any agreeing cycle clears the debounce counter.
REQ-014 A button request SHALL be a one-cycle event on the debounced released->pressed transition.
REQ-015 The block SHALL implement the FSM states ASSERT, RELEASE and RUN.
REQ-016 ASSERT: all rst_n_out bits low; the counter increments each cycle but is held at 0 while the debounced button is pressed; after count MIN_ASSERT-1 the FSM SHALL enter RELEASE with the counter cleared and stage index 0.
REQ-017 RELEASE: after STAGE_LEN cycles, rst_n_out[stage] SHALL go high, the counter SHALL clear and the stage SHALL increment; after the last stage the FSM SHALL enter RUN.
REQ-018 RUN: all rst_n_out bits high and busy low; the FSM SHALL remain here until a request.
REQ-019 A button request or sw_req in any state SHALL, on the next edge, drive all rst_n_out bits low, enter ASSERT, clear the counter and the stage index, and update cause; a request during ASSERT or RELEASE SHALL restart the full sequence.
REQ-020 For simultaneous button and software requests, cause SHALL be set to 1 (button).
REQ-021 rst_n_out, busy and cause SHALL be registered outputs with no combinational path from the inputs.
REQ-022 busy SHALL equal NOT(AND of rst_n_out) in every cycle.
REQ-023 The counter width SHALL be $clog2(max(MIN_ASSERT, STAGE_LEN, DEBOUNCE_LEN)+1) bits, and the counters SHALL never wrap.
REQ-024 With no further requests, rst_n_out[k] SHALL rise exactly MIN_ASSERT+(k+1)*STAGE_LEN edges after the last edge that sampled reset high or accepted a request.

Reset
REQ-025 While reset is high, the block SHALL hold: state ASSERT, counters 0, stage 0, rst_n_out all 0, busy 1, cause 0, synchronizer flops 1, debounced state released.
REQ-026 reset SHALL take priority over all requests in the same cycle.
REQ-027 Reset asserted mid-sequence or in RUN SHALL restart from ASSERT, with cause 0.
REQ-028 The block SHALL need no initial values beyond the reset behaviour.

Verification
REQ-029 The bench SHALL cover: reset high 5 cycles then low with defaults -> rst_n_out = 000 until edge 47; bit0 at 47, bit1 at 63, bit2 at 79; busy falls at 79; cause = 0.
REQ-030 The bench SHALL cover: in RUN, a 1-cycle sw_req -> next edge rst_n_out = 000, busy = 1, cause = 2; bit0 rises 47 edges after the request edge.
REQ-031 The bench SHALL cover: btn_n low for 300 cycles, then high -> press accepted DEBOUNCE_LEN+2 edges after the fall, cause = 1; ASSERT is held while the button is pressed; release follows MIN_ASSERT+STAGE_LEN edges after the debounced release.
REQ-032 The bench SHALL cover: btn_n glitches low for 100 cycles -> no request, and rst_n_out stays 111.
REQ-033 The bench SHALL cover: sw_req during RELEASE after bit0 has risen -> all bits low next edge, and the full sequence restarts.
REQ-034 The bench SHALL cover: sw_req coincident with reset high -> sw_req ignored, cause = 0, timing per REQ-029.

Source files
------------

// File: rtl/reset_seq.sv
`default_nettype none
// ============================================================================
// reset_seq : debounced-button / software / port reset sequencer that releases
//             NUM_STAGES active-low resets one after another.
// Revision  : 1.0
// ============================================================================
module reset_seq #(
  parameter int NUM_STAGES   = 3,
  parameter int MIN_ASSERT   = 31,
  parameter int STAGE_LEN    = 16,
  parameter int DEBOUNCE_LEN = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_n,
  input  logic                  sw_req,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  busy,
  output logic [1:0]            cause
);

  localparam int MAX_A = (MIN_ASSERT > STAGE_LEN) ? MIN_ASSERT : STAGE_LEN;
  localparam int MAX_V = (MAX_A > DEBOUNCE_LEN) ? MAX_A : DEBOUNCE_LEN;
  localparam int CW    = $clog2(MAX_V + 1);
  localparam int SW    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_LEN - 1);
  localparam logic [CW-1:0] ASSERT_LAST = CW'(MIN_ASSERT - 1);
  localparam logic [CW-1:0] STAGE_LAST  = CW'(STAGE_LEN - 1);
  localparam logic [SW-1:0] LAST_STAGE  = SW'(NUM_STAGES - 1);

  localparam logic [1:0] CAUSE_PORT = 2'd0;
  localparam logic [1:0] CAUSE_BTN  = 2'd1;
  localparam logic [1:0] CAUSE_SW   = 2'd2;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  logic          sync1;
  logic          sync2;
  logic          db_pressed;
  logic [CW-1:0] db_cnt;
  logic          btn_pressed;
  logic          btn_req;
  logic          req;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] stage;

  assign btn_pressed = ~sync2;
  // The press is acted on in the same edge the debounced state flips.
  assign btn_req     = btn_pressed & ~db_pressed & (db_cnt == DB_LAST);
  assign req         = btn_req | sw_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      db_pressed <= 1'b0;
      db_cnt     <= '0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      if (btn_pressed != db_pressed) begin
        if (db_cnt == DB_LAST) begin
          db_pressed <= btn_pressed;
          db_cnt     <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_ASSERT;
      cnt       <= '0;
      stage     <= '0;
      rst_n_out <= '0;
      busy      <= 1'b1;
      cause     <= CAUSE_PORT;
    end else if (req) begin
      state     <= ST_ASSERT;
      cnt       <= '0;
      stage     <= '0;
      rst_n_out <= '0;
      busy      <= 1'b1;
      cause     <= btn_req ? CAUSE_BTN : CAUSE_SW;
    end else begin
      case (state)
        ST_ASSERT: begin
          // A held button keeps the whole system in reset.
          if (db_pressed) begin
            cnt <= '0;
          end else if (cnt == ASSERT_LAST) begin
            state <= ST_RELEASE;
            cnt   <= '0;
            stage <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt == STAGE_LAST) begin
            rst_n_out[stage] <= 1'b1;
            cnt              <= '0;
            if (stage == LAST_STAGE) begin
              state <= ST_RUN;
              busy  <= 1'b0;
            end else begin
              stage <= stage + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          cnt <= '0;
        end
        default: begin
          state     <= ST_ASSERT;
          cnt       <= '0;
          stage     <= '0;
          rst_n_out <= '0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
